// File: rtl/rf_port_scheduler.sv
// rf_port_scheduler: owns the single read-or-write command port of the 32x32 register file.
// It buffers writeback requests in an in-order FIFO, holds one outstanding operand read,
// keeps read-after-write ordering, alternates grants under contention and runs the register
// file clear pulse after every reset.
//
// Optional feature macro: RF_BYPASS_EN. When defined, a read that matches buffered writes
// issues without stalling and returns the youngest matching buffered data.
//
// Ports:
//   clk_i, rst_ni                      clock, asynchronous active-low reset
//   wr_valid_i/wr_ready_o, wr_addr_i, wr_data_i   writeback request
//   rd_valid_i/rd_ready_o, rd_addr1_i, rd_addr2_i operand-read request
//   rsp_valid_o, rsp_data1_o, rsp_data2_o         one-cycle read response, zero when idle
//   init_done_o                                   clear sequence complete
//   rf_en_o, rf_reset_o, rf_read_en_o, rf_write_en_o, rf_rs1_o, rf_rs2_o, rf_rd_o,
//   rf_data_in_o                                  register-file command port
//   rf_read_out1_i, rf_read_out2_i                register-file read data
module rf_port_scheduler #(
    parameter int unsigned WBUF_DEPTH = 2,
    parameter int unsigned AW         = 5,
    parameter int unsigned DW         = 32
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          wr_valid_i,
    output logic          wr_ready_o,
    input  logic [AW-1:0] wr_addr_i,
    input  logic [DW-1:0] wr_data_i,
    input  logic          rd_valid_i,
    output logic          rd_ready_o,
    input  logic [AW-1:0] rd_addr1_i,
    input  logic [AW-1:0] rd_addr2_i,
    output logic          rsp_valid_o,
    output logic [DW-1:0] rsp_data1_o,
    output logic [DW-1:0] rsp_data2_o,
    output logic          init_done_o,
    output logic          rf_en_o,
    output logic          rf_reset_o,
    output logic          rf_read_en_o,
    output logic          rf_write_en_o,
    output logic [AW-1:0] rf_rs1_o,
    output logic [AW-1:0] rf_rs2_o,
    output logic [AW-1:0] rf_rd_o,
    output logic [DW-1:0] rf_data_in_o,
    input  logic [DW-1:0] rf_read_out1_i,
    input  logic [DW-1:0] rf_read_out2_i
);
    localparam int unsigned PW = $clog2(WBUF_DEPTH);

    typedef enum logic [1:0] {StInit, StIdle, StRdWait} state_e;

    state_e                state_q, state_d;
    logic                  init_go_q;   // first cycle after reset release seen
    logic                  init_done_q;
    logic                  last_wr_q;   // last grant was a write
    logic                  rd_pend_q;
    logic [AW-1:0]         rs1_q, rs2_q;
    logic [PW-1:0]         wptr_q, rptr_q;
    logic [WBUF_DEPTH-1:0] valid_q;
    logic [AW-1:0]         addr_q [WBUF_DEPTH];
    logic [DW-1:0]         data_q [WBUF_DEPTH];

    logic full, empty, hazard, push, accept_rd, issue_rd, issue_wr, init_pulse, rd_block;

`ifdef RF_BYPASS_EN
    logic          byp1_hit_q, byp2_hit_q, snap1_hit, snap2_hit;
    logic [DW-1:0] byp1_q, byp2_q, snap1, snap2;
    logic [PW-1:0] idx;

    // Walk oldest to youngest so the youngest matching entry wins.
    always_comb begin
        snap1_hit = 1'b0;
        snap2_hit = 1'b0;
        snap1     = '0;
        snap2     = '0;
        idx       = '0;
        for (int k = 0; k < WBUF_DEPTH; k++) begin
            idx = rptr_q + PW'(k);
            if (valid_q[idx] && addr_q[idx] == rs1_q) begin
                snap1_hit = 1'b1;
                snap1     = data_q[idx];
            end
            if (valid_q[idx] && addr_q[idx] == rs2_q) begin
                snap2_hit = 1'b1;
                snap2     = data_q[idx];
            end
        end
    end
`endif

    always_comb begin
        hazard = 1'b0;
        for (int i = 0; i < WBUF_DEPTH; i++) begin
            if (valid_q[i] && (addr_q[i] == rs1_q || addr_q[i] == rs2_q)) hazard = 1'b1;
        end
    end

`ifdef RF_BYPASS_EN
    assign rd_block = 1'b0;
`else
    assign rd_block = hazard;
`endif

    assign full       = &valid_q;
    assign empty      = ~|valid_q;
    assign wr_ready_o = init_done_q && !full;
    assign rd_ready_o = init_done_q && (state_q == StIdle) && !rd_pend_q;
    assign push       = wr_valid_i && wr_ready_o;
    assign accept_rd  = rd_valid_i && rd_ready_o;
    assign init_pulse = (state_q == StInit) && init_go_q;
    assign issue_rd   = (state_q == StIdle) && rd_pend_q && !rd_block && (empty || last_wr_q);
    assign issue_wr   = ((state_q == StIdle) || (state_q == StRdWait)) && !empty && !issue_rd;
    assign init_done_o = init_done_q;

    always_comb begin
        rf_en_o       = init_pulse || issue_rd || issue_wr;
        rf_reset_o    = init_pulse;
        rf_read_en_o  = issue_rd;
        rf_write_en_o = issue_wr;
        rf_rs1_o      = issue_rd ? rs1_q : '0;
        rf_rs2_o      = issue_rd ? rs2_q : '0;
        rf_rd_o       = issue_wr ? addr_q[rptr_q] : '0;
        rf_data_in_o  = issue_wr ? data_q[rptr_q] : '0;
    end

    assign rsp_valid_o = (state_q == StRdWait);

    always_comb begin
        rsp_data1_o = '0;
        rsp_data2_o = '0;
        if (rsp_valid_o) begin
`ifdef RF_BYPASS_EN
            rsp_data1_o = byp1_hit_q ? byp1_q : rf_read_out1_i;
            rsp_data2_o = byp2_hit_q ? byp2_q : rf_read_out2_i;
`else
            rsp_data1_o = rf_read_out1_i;
            rsp_data2_o = rf_read_out2_i;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StInit:   if (init_go_q) state_d = StIdle;
            StIdle:   if (issue_rd) state_d = StRdWait;
            StRdWait: state_d = StIdle;
            default:  state_d = StInit;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StInit;
            init_go_q   <= 1'b0;
            init_done_q <= 1'b0;
            last_wr_q   <= 1'b1;
            rd_pend_q   <= 1'b0;
            rs1_q       <= '0;
            rs2_q       <= '0;
            wptr_q      <= '0;
            rptr_q      <= '0;
            valid_q     <= '0;
            for (int i = 0; i < WBUF_DEPTH; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
            end
`ifdef RF_BYPASS_EN
            byp1_hit_q <= 1'b0;
            byp2_hit_q <= 1'b0;
            byp1_q     <= '0;
            byp2_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            init_go_q <= 1'b1;
            if (init_pulse) init_done_q <= 1'b1;
            if (state_q == StRdWait) rd_pend_q <= 1'b0;
            if (accept_rd) begin
                rd_pend_q <= 1'b1;
                rs1_q     <= rd_addr1_i;
                rs2_q     <= rd_addr2_i;
            end
            if (issue_rd) last_wr_q <= 1'b0;
            if (issue_wr) begin
                last_wr_q       <= 1'b1;
                valid_q[rptr_q] <= 1'b0;
                rptr_q          <= rptr_q + 1'b1;
            end
            // Push never targets the head slot being popped: push needs !full, pop needs !empty.
            if (push) begin
                valid_q[wptr_q] <= 1'b1;
                addr_q[wptr_q]  <= wr_addr_i;
                data_q[wptr_q]  <= wr_data_i;
                wptr_q          <= wptr_q + 1'b1;
            end
`ifdef RF_BYPASS_EN
            if (issue_rd) begin
                byp1_hit_q <= snap1_hit;
                byp2_hit_q <= snap2_hit;
                byp1_q     <= snap1;
                byp2_q     <= snap2;
            end
`endif
        end
    end

endmodule
